// File: rtl/mem_share_arbiter.sv
// mem_share_arbiter
// Shares one synchronous-read, single-port RAM between three requesters:
//   - the HPS download stream, which cannot stall and is buffered in a small write FIFO
//   - the game CPU (req/ack handshake)
//   - the high-score save/restore engine (req/ack handshake)
// Every transaction takes exactly four cycles: IDLE -> ACC -> RESP -> DONE.
// Grants are decided only in IDLE, so a requester that drops req at the edge that
// ends its ack cycle cannot be granted a second time by accident.
module mem_share_arbiter #(
    parameter int AW         = 18,
    parameter int DW         = 8,
    parameter int DN_DEPTH   = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk_sys,
    input  logic          reset,
    // download stream
    input  logic [AW-1:0] dn_addr,
    input  logic [DW-1:0] dn_data,
    input  logic          dn_wr,
    output logic          dn_ovf,
    // game CPU
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_din,
    output logic          cpu_ack,
    output logic [DW-1:0] cpu_dout,
    // high-score engine
    input  logic          hs_req,
    input  logic          hs_we,
    input  logic [AW-1:0] hs_addr,
    input  logic [DW-1:0] hs_din,
    output logic          hs_ack,
    output logic [DW-1:0] hs_dout,
    // RAM
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    output logic          mem_we,
    input  logic [DW-1:0] mem_dout,
    output logic          busy
);

    localparam int PW = (DN_DEPTH > 1) ? $clog2(DN_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC  = 2'd1,
        S_RESP = 2'd2,
        S_DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_DN   = 2'd1,
        G_CPU  = 2'd2,
        G_HS   = 2'd3
    } gnt_t;

    // registers
    state_t              r_state;
    gnt_t                r_gnt;
    logic                r_gnt_we;
    logic [AW+DW-1:0]    r_fifo [DN_DEPTH];
    logic [PW-1:0]       r_wr_ptr;
    logic [PW-1:0]       r_rd_ptr;
    logic [CW-1:0]       r_count;
    logic                r_dn_ovf;
    logic [SW-1:0]       r_starve;
    logic [AW-1:0]       r_mem_addr;
    logic [DW-1:0]       r_mem_din;
    logic                r_mem_we;
    logic                r_cpu_ack;
    logic                r_hs_ack;
    logic [DW-1:0]       r_cpu_dout;
    logic [DW-1:0]       r_hs_dout;
    logic                r_busy;

    // wires
    state_t              w_state_nxt;
    gnt_t                w_gnt_nxt;
    logic                w_pop;
    logic                w_push;
    logic [CW-1:0]       w_count_nxt;
    logic                w_fifo_empty;
    logic                w_fifo_full;
    logic [AW+DW-1:0]    w_head;
    logic                w_starved;
    logic [AW-1:0]       w_sel_addr;
    logic [DW-1:0]       w_sel_din;
    logic                w_sel_we;
    logic                w_busy_nxt;

    assign w_fifo_empty = (r_count == {CW{1'b0}});
    assign w_fifo_full  = (r_count == CW'(DN_DEPTH));
    assign w_head       = r_fifo[r_rd_ptr];
    assign w_starved    = (r_starve == SW'(STARVE_MAX));
    // a full FIFO still accepts a push when the head leaves in the same cycle
    assign w_push       = dn_wr && (!w_fifo_full || w_pop);
    assign w_busy_nxt   = (w_state_nxt != S_IDLE) || (w_count_nxt != {CW{1'b0}});

    // Next-state, grant decision and selection of the winning source's address/data
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = G_NONE;
        w_pop       = 1'b0;
        w_sel_addr  = {AW{1'b0}};
        w_sel_din   = {DW{1'b0}};
        w_sel_we    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_fifo_empty) begin
                    w_gnt_nxt   = G_DN;
                    w_pop       = 1'b1;
                    w_sel_addr  = w_head[AW+DW-1:DW];
                    w_sel_din   = w_head[DW-1:0];
                    w_sel_we    = 1'b1;
                    w_state_nxt = S_ACC;
                end else if (hs_req && w_starved) begin
                    w_gnt_nxt   = G_HS;
                    w_sel_addr  = hs_addr;
                    w_sel_din   = hs_din;
                    w_sel_we    = hs_we;
                    w_state_nxt = S_ACC;
                end else if (cpu_req) begin
                    w_gnt_nxt   = G_CPU;
                    w_sel_addr  = cpu_addr;
                    w_sel_din   = cpu_din;
                    w_sel_we    = cpu_we;
                    w_state_nxt = S_ACC;
                end else if (hs_req) begin
                    w_gnt_nxt   = G_HS;
                    w_sel_addr  = hs_addr;
                    w_sel_din   = hs_din;
                    w_sel_we    = hs_we;
                    w_state_nxt = S_ACC;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACC:   w_state_nxt = S_RESP;
            S_RESP:  w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Next FIFO occupancy from this cycle's push/pop pair
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FIFO payload storage (contents are don't-care while the entry is unoccupied)
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {dn_addr, dn_data};
        end
    end

    // FIFO pointers, occupancy and sticky overflow flag
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CW{1'b0}};
            r_dn_ovf <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= w_count_nxt;
            if (dn_wr && !w_push) begin
                r_dn_ovf <= 1'b1;
            end
        end
    end

    // Latch grant, address and data at the grant edge; write enable lasts only for ACC
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_gnt      <= G_NONE;
            r_gnt_we   <= 1'b0;
            r_mem_addr <= {AW{1'b0}};
            r_mem_din  <= {DW{1'b0}};
            r_mem_we   <= 1'b0;
        end else if (w_gnt_nxt != G_NONE) begin
            r_gnt      <= w_gnt_nxt;
            r_gnt_we   <= w_sel_we;
            r_mem_addr <= w_sel_addr;
            r_mem_din  <= w_sel_din;
            r_mem_we   <= w_sel_we;
        end else begin
            r_mem_we   <= 1'b0;
        end
    end

    // Count CPU grants that bypass a waiting high-score request
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_starve <= {SW{1'b0}};
        end else if (w_gnt_nxt == G_HS) begin
            r_starve <= {SW{1'b0}};
        end else if ((w_gnt_nxt == G_CPU) && hs_req && !w_starved) begin
            r_starve <= r_starve + SW'(1);
        end else begin
            r_starve <= r_starve;
        end
    end

    // Capture read data at the end of RESP and pulse the owner's ack during DONE
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_cpu_ack  <= 1'b0;
            r_hs_ack   <= 1'b0;
            r_cpu_dout <= {DW{1'b0}};
            r_hs_dout  <= {DW{1'b0}};
        end else begin
            r_cpu_ack <= (r_state == S_RESP) && (r_gnt == G_CPU);
            r_hs_ack  <= (r_state == S_RESP) && (r_gnt == G_HS);
            if ((r_state == S_RESP) && (r_gnt == G_CPU) && !r_gnt_we) begin
                r_cpu_dout <= mem_dout;
            end
            if ((r_state == S_RESP) && (r_gnt == G_HS) && !r_gnt_we) begin
                r_hs_dout <= mem_dout;
            end
        end
    end

    // Busy reflects the state and FIFO occupancy that take effect after this edge
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_busy <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    assign dn_ovf   = r_dn_ovf;
    assign cpu_ack  = r_cpu_ack;
    assign cpu_dout = r_cpu_dout;
    assign hs_ack   = r_hs_ack;
    assign hs_dout  = r_hs_dout;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;
    assign mem_we   = r_mem_we;
    assign busy     = r_busy;

endmodule

// File: tb/tb_mem_share_arbiter.sv
// Self-checking bench for mem_share_arbiter: a cycle table for the handshake
// requesters plus hand-written sequences for the download burst, reset abort,
// priority and starvation cases. A behavioural synchronous-read RAM is attached.
module tb_mem_share_arbiter;

    localparam int AW = 18;
    localparam int DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic [AW-1:0] dn_addr;
    logic [DW-1:0] dn_data;
    logic          dn_wr;
    logic          dn_ovf;
    logic          cpu_req, cpu_we, cpu_ack;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_din, cpu_dout;
    logic          hs_req, hs_we, hs_ack;
    logic [AW-1:0] hs_addr;
    logic [DW-1:0] hs_din, hs_dout;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic          mem_we;
    logic [DW-1:0] mem_dout;
    logic          busy;

    int errors = 0;
    int checks = 0;

    always #5 clk_sys = ~clk_sys;

    mem_share_arbiter #(
        .AW(AW), .DW(DW), .DN_DEPTH(4), .STARVE_MAX(2)
    ) dut (
        .clk_sys(clk_sys), .reset(reset),
        .dn_addr(dn_addr), .dn_data(dn_data), .dn_wr(dn_wr), .dn_ovf(dn_ovf),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
        .hs_req(hs_req), .hs_we(hs_we), .hs_addr(hs_addr), .hs_din(hs_din),
        .hs_ack(hs_ack), .hs_dout(hs_dout),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
        .busy(busy)
    );

    // Behavioural synchronous-read RAM with a bench-side preload port
    logic [DW-1:0] ram [0:(1<<AW)-1];
    logic          pre_we = 1'b0;
    logic [AW-1:0] pre_addr = '0;
    logic [DW-1:0] pre_data = '0;

    always @(posedge clk_sys) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        else if (pre_we) ram[pre_addr] <= pre_data;
        mem_dout <= ram[mem_addr];
    end

    typedef struct {
        logic          cr; logic cw; logic [AW-1:0] ca; logic [DW-1:0] cd;
        logic          hr; logic hw; logic [AW-1:0] ha; logic [DW-1:0] hd;
        logic [AW-1:0] e_addr; logic [DW-1:0] e_din; logic e_we;
        logic          e_cack; logic e_hack;
        logic [DW-1:0] e_cdout; logic [DW-1:0] e_hdout; logic e_busy;
    } vec_t;

    vec_t tbl [25];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        dn_wr = 1'b0; dn_addr = '0; dn_data = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_din = '0;
        hs_req = 1'b0; hs_we = 1'b0; hs_addr = '0; hs_din = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk_sys);
        #1;
        reset = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    logic          rec_we   [32];
    logic [AW-1:0] rec_addr [32];
    logic          rec_cack [32];
    logic          rec_hack [32];

    initial begin
        int wr_edge [$];
        logic [AW-1:0] wr_addr [$];
        logic [DW-1:0] wr_din [$];
        int seen;
        int n_c;
        int n_h;
        bit c_drop;
        bit h_drop;

        //            cr    cw    ca         cd     hr    hw    ha         hd     | addr       din    we    cack  hack  cdout  hdout  busy
        tbl[0]  = '{1'b1, 1'b0, 18'h00123, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[1]  = '{1'b1, 1'b0, 18'h00123, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1};
        tbl[2]  = '{1'b1, 1'b0, 18'h00123, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b1};
        tbl[3]  = '{1'b1, 1'b0, 18'h00123, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b1, 18'h1FFFF, 8'h3C, 18'h1FFFF, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 18'h00777, 8'hEE, 1'b1, 1'b1, 18'h00000, 8'h3C, 18'h1FFFF, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1};
        tbl[7]  = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b1, 18'h00000, 8'h3C, 18'h1FFFF, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h5A, 8'h00, 1'b1};
        tbl[8]  = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b1, 18'h00000, 8'h3C, 18'h1FFFF, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h1FFFF, 8'h3C, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 18'h1FFFF, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h1FFFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 18'h00123, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h1FFFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h5A, 8'h00, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 18'h00123, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h1FFFF, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h00, 1'b1};
        tbl[13] = '{1'b1, 1'b0, 18'h00123, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h1FFFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h1FFFF, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b0, 18'h00123, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1};
        tbl[16] = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b0, 18'h00123, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h00, 1'b1};
        tbl[17] = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b0, 18'h00123, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b1, 8'h3C, 8'h5A, 1'b1};
        tbl[18] = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b1, 1'b0, 18'h00123, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00123, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 1'b0};
        tbl[20] = '{1'b1, 1'b1, 18'h00456, 8'h99, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00456, 8'h99, 1'b1, 1'b0, 1'b0, 8'h3C, 8'h5A, 1'b1};
        tbl[21] = '{1'b1, 1'b1, 18'h00456, 8'h99, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00456, 8'h99, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 1'b1};
        tbl[22] = '{1'b1, 1'b1, 18'h00456, 8'h99, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00456, 8'h99, 1'b0, 1'b1, 1'b0, 8'h3C, 8'h5A, 1'b1};
        tbl[23] = '{1'b1, 1'b1, 18'h00456, 8'h99, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00456, 8'h99, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 18'h00000, 8'h00, 1'b0, 1'b0, 18'h00000, 8'h00, 18'h00456, 8'h99, 1'b0, 1'b0, 1'b0, 8'h3C, 8'h5A, 1'b0};

        // ---------------- reset state ----------------
        do_reset();
        check("reset_outputs",
              {mem_addr, mem_din, mem_we, cpu_ack, hs_ack, cpu_dout, hs_dout, busy, dn_ovf},
              64'h0);

        // preload RAM[0x00123] = 0x5A while the arbiter is idle
        pre_we = 1'b1; pre_addr = 18'h00123; pre_data = 8'h5A;
        tick();
        pre_we = 1'b0;

        // ---------------- table: handshake requesters ----------------
        for (int i = 0; i < 25; i++) begin
            cpu_req = tbl[i].cr; cpu_we = tbl[i].cw; cpu_addr = tbl[i].ca; cpu_din = tbl[i].cd;
            hs_req  = tbl[i].hr; hs_we  = tbl[i].hw; hs_addr  = tbl[i].ha; hs_din  = tbl[i].hd;
            tick();
            check($sformatf("vec%0d", i),
                  {mem_addr, mem_din, mem_we, cpu_ack, hs_ack, cpu_dout, hs_dout, busy},
                  {tbl[i].e_addr, tbl[i].e_din, tbl[i].e_we, tbl[i].e_cack, tbl[i].e_hack,
                   tbl[i].e_cdout, tbl[i].e_hdout, tbl[i].e_busy});
        end
        check("ram_hs_write", ram[18'h1FFFF], 8'h3C);
        check("ram_cpu_write", ram[18'h00456], 8'h99);

        // ---------------- download burst with overflow ----------------
        do_reset();
        for (int k = 0; k < 25; k++) begin
            if (k < 7) begin
                dn_wr = 1'b1; dn_addr = AW'(k); dn_data = 8'hA0 + 8'(k);
            end else begin
                dn_wr = 1'b0;
            end
            tick();
            if (mem_we) begin
                wr_edge.push_back(k); wr_addr.push_back(mem_addr); wr_din.push_back(mem_din);
            end
            if (k == 5) check("ovf_before_drop", dn_ovf, 1'b0);
            if (k == 6) check("ovf_after_drop", dn_ovf, 1'b1);
            if (k == 23) check("busy_last_done", busy, 1'b1);
            if (k == 24) check("busy_fall", busy, 1'b0);
        end
        check("burst_write_count", wr_edge.size(), 6);
        for (int i = 0; i < 6; i++) begin
            if (i < wr_edge.size()) begin
                check($sformatf("burst_pop_edge%0d", i), wr_edge[i], 1 + 4 * i);
                check($sformatf("burst_addr%0d", i), wr_addr[i], i);
                check($sformatf("burst_din%0d", i), wr_din[i], 8'hA0 + 8'(i));
            end
            check($sformatf("burst_ram%0d", i), ram[i], 8'hA0 + 8'(i));
        end

        // ---------------- reset in the middle of a CPU write ----------------
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 18'h00010; cpu_din = 8'h77;
        dn_wr = 1'b1; dn_addr = 18'h00020; dn_data = 8'h55;
        tick();
        check("rst_acc_write", {mem_we, mem_addr}, {1'b1, 18'h00010});
        check("rst_ovf_sticky", dn_ovf, 1'b1);
        reset = 1'b1; dn_wr = 1'b0;
        tick();
        check("rst_abort", {mem_we, cpu_ack, busy, dn_ovf}, 4'b0000);
        reset = 1'b0; cpu_req = 1'b0;
        seen = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (mem_we || cpu_ack || busy) seen++;
        end
        check("rst_quiet_after", seen, 0);

        // ---------------- priority: download, then CPU, then hs ----------------
        do_reset();
        dn_wr = 1'b1; dn_addr = 18'h00200; dn_data = 8'h11;
        tick();
        dn_wr = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00300;
        hs_req  = 1'b1; hs_we  = 1'b0; hs_addr  = 18'h00400;
        c_drop = 1'b0; h_drop = 1'b0; n_c = 0; n_h = 0;
        for (int k = 1; k < 16; k++) begin
            tick();
            if (c_drop) begin cpu_req = 1'b0; c_drop = 1'b0; end
            if (h_drop) begin hs_req = 1'b0; h_drop = 1'b0; end
            if (cpu_ack) begin c_drop = 1'b1; n_c++; end
            if (hs_ack) begin h_drop = 1'b1; n_h++; end
            rec_we[k] = mem_we; rec_addr[k] = mem_addr;
            rec_cack[k] = cpu_ack; rec_hack[k] = hs_ack;
        end
        check("prio_dn_first", {rec_we[1], rec_addr[1]}, {1'b1, 18'h00200});
        check("prio_dn_no_ack", {rec_cack[3], rec_hack[3]}, 2'b00);
        check("prio_cpu_second", rec_addr[5], 18'h00300);
        check("prio_cpu_ack", rec_cack[7], 1'b1);
        check("prio_hs_third", rec_addr[9], 18'h00400);
        check("prio_hs_ack", rec_hack[11], 1'b1);
        check("prio_ack_counts", {n_c[7:0], n_h[7:0]}, {8'd1, 8'd1});

        // ---------------- starvation guard (STARVE_MAX = 2) ----------------
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 18'h00500;
        hs_req  = 1'b1; hs_we  = 1'b0; hs_addr  = 18'h00600;
        n_h = 0;
        for (int k = 0; k < 24; k++) begin
            tick();
            rec_addr[k] = mem_addr; rec_cack[k] = cpu_ack; rec_hack[k] = hs_ack;
            if (hs_ack) n_h++;
        end
        for (int t = 0; t < 6; t++) begin
            check($sformatf("starve_grant%0d", t), rec_addr[4 * t],
                  (t % 3 == 2) ? 18'h00600 : 18'h00500);
            check($sformatf("starve_ack%0d", t), {rec_cack[4 * t + 2], rec_hack[4 * t + 2]},
                  (t % 3 == 2) ? 2'b01 : 2'b10);
        end
        check("starve_hs_pulses", n_h, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_share_arbiter.md
Name: mem_share_arbiter

Overview:
- Shares the single-port program/graphics RAM between three requesters: the HPS ROM download stream (ioctl), the game CPU, and the high-score save/restore engine.
- The download stream cannot stall, so it enters through a small write FIFO. CPU and high-score engine use a req/ack handshake.
- Sits in the clk_sys domain between hps_io and williams2. The RAM is synchronous-read.

Parameters:
- AW, 18, address width (matches dn_addr[17:0])
- DW, 8, data width
- DN_DEPTH, 4, download FIFO entries (power of 2)
- STARVE_MAX, 4, consecutive CPU grants tolerated while hs_req pending

Ports:
- clk_sys  in  1  system clock
- reset  in  1  synchronous, active-high reset
- dn_addr  in  AW  download address
- dn_data  in  DW  download byte
- dn_wr  in  1  one-cycle download write strobe
- dn_ovf  out  1  sticky: a download write was dropped
- cpu_req  in  1  CPU request, held until ack
- cpu_we  in  1  1=write, 0=read
- cpu_addr  in  AW  CPU address
- cpu_din  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_dout  out  DW  CPU read data
- hs_req / hs_we / hs_addr / hs_din / hs_ack / hs_dout  as the CPU set, for the high-score engine
- mem_addr  out  AW  RAM address
- mem_din  out  DW  RAM write data
- mem_we  out  1  RAM write enable
- mem_dout  in  DW  RAM read data, valid the cycle after the address is presented
- busy  out  1  high when state!=IDLE or FIFO is non-empty

Behaviour:
- Reset values: all outputs 0. FIFO empty, state IDLE, starvation counter 0, dn_ovf 0. Reset mid-transaction aborts it: the next cycle has mem_we=0 and no ack is issued.
- FIFO:
  - A dn_wr sampled high pushes {dn_addr, dn_data}.
  - Push while full with no pop in the same cycle: the entry is dropped and dn_ovf is set (sticky until reset).
  - Push while full with a simultaneous pop: accepted.
  - Entries are written to RAM in push order.
- FSM states: IDLE -> ACC -> RESP -> DONE -> IDLE. A transaction is exactly 4 cycles.
- IDLE: at the clock edge, if any source is pending, latch the grant, go to ACC, and pop the FIFO if the download source wins. No pending source: stay in IDLE.
- Priority:
  - FIFO non-empty always wins.
  - Otherwise, if hs_req is high and the counter equals STARVE_MAX, hs wins.
  - Otherwise cpu beats hs.
- Starvation counter:
  - Increments on each CPU grant while hs_req is high, saturating at STARVE_MAX.
  - Clears on an hs grant.
- ACC: mem_addr and mem_din are driven from the granted source. mem_we=1 only in this cycle, and only for writes (download entries are always writes).
- RESP: mem_addr is held. At the end of the cycle, read data is registered into the granted requester's dout.
- DONE: the granted requester's ack is high for this one cycle. Download grants produce no ack.
- dout holds its value until that requester's next read completes. Writes leave dout unchanged.
- Requester rule: the requester drops req at the edge that ends its ack cycle. The following IDLE cycle guarantees it is not re-granted unless it re-asserts.
- A request whose req falls before it is granted is withdrawn without side effects.
- Address and data are sampled only at the grant edge. Changes after that are ignored.

Test Plan:
- Single read: RAM[0x00123]=0x5A, cpu_req with cpu_we=0 sampled at edge e -> mem_addr=0x00123 from e, cpu_ack high only in cycle [e+2,e+3), cpu_dout=0x5A, mem_we never high.
- Download burst: 7 dn_wr on consecutive edges 0..6, addresses 0..6, data 0xA0..0xA6 -> pops at edges 1,5,9,13,17,21; the 7th write (address 6) is dropped; dn_ovf=1 after edge 6; RAM[0..5]=0xA0..0xA5; busy falls after the last DONE.
- Priority: FIFO non-empty, cpu_req and hs_req all high at the same IDLE edge -> download first, then CPU, then hs; no acks in the download DONE cycle.
- Starvation: STARVE_MAX=2, hs_req held, CPU re-asserts req in every IDLE cycle -> grant order cpu, cpu, hs, cpu, cpu, hs; hs_ack pulses once per hs grant.
- Reset mid-write: cpu write to 0x00010 and reset asserted during ACC -> next cycle mem_we=0, no cpu_ack, state IDLE, FIFO empty, dn_ovf=0, busy=0.
- Write then read: hs writes 0x3C to 0x1FFFF, then cpu reads 0x1FFFF -> cpu_dout=0x3C; hs_dout keeps its prior value.
